// File: rtl/iob_timer_counter.sv
// iob_timer_counter
// Free-running 2*DATA_W cycle counter with a snapshot register.
// Software sets TIMER_ENABLE to let the counter run. It pulses TIMER_SAMPLE
// to freeze the current count into TIMER_VALUE, so a wide value can be read
// coherently over a narrower bus. cke_i stalls every register.
// Reset is synchronous and overrides cke_i.

module iob_timer_counter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cke_i,
  input  logic                  TIMER_ENABLE,
  input  logic                  TIMER_SAMPLE,
  output logic [2*DATA_W-1:0]   TIMER_VALUE
);

  localparam int               CNT_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Running count: advances on enabled cycles and wraps silently at full scale.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      cnt <= '0;
    end else if (cke_i && TIMER_ENABLE) begin
      cnt <= cnt + ONE;
    end
  end

  // Snapshot register: captures the pre-edge count, so a sample taken while
  // counting returns the value before this edge's increment.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      TIMER_VALUE <= '0;
    end else if (cke_i && TIMER_SAMPLE) begin
      TIMER_VALUE <= cnt;
    end
  end

endmodule

// File: tb/tb_iob_timer_counter.sv
// Testbench for iob_timer_counter: directed scenarios plus random traffic,
// checked every cycle against a behavioural model, with literal spot values.

module tb_iob_timer_counter;

  localparam int DATA_W = 32;
  localparam int W      = 2 * DATA_W;

  logic         clk_i = 1'b0;
  logic         arst_i = 1'b0;
  logic         cke_i = 1'b1;
  logic         TIMER_ENABLE = 1'b0;
  logic         TIMER_SAMPLE = 1'b0;
  logic [W-1:0] TIMER_VALUE;

  iob_timer_counter #(.DATA_W(DATA_W)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .cke_i        (cke_i),
    .TIMER_ENABLE (TIMER_ENABLE),
    .TIMER_SAMPLE (TIMER_SAMPLE),
    .TIMER_VALUE  (TIMER_VALUE)
  );

  always #5 clk_i = ~clk_i;

  // Model state (owned by the model process)
  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_val = '0;
  bit           m_valid = 1'b0;
  int           dep_seen = 0;

  // Deposit request (owned by the stimulus process)
  int           dep_seq = 0;
  logic [W-1:0] dep_val = '0;

  // Literal check request (owned by the stimulus process)
  int           lit_seq = 0;
  int           lit_seen = 0;
  logic [W-1:0] lit_exp = '0;
  string        lit_name = "";

  int checks = 0;
  int errors = 0;

  // Behavioural model: what each register must hold after a rising edge.
  always @(posedge clk_i) begin
    if (dep_seq != dep_seen) begin
      m_cnt    = dep_val;
      dep_seen = dep_seq;
    end
    if (arst_i) begin
      m_cnt   = '0;
      m_val   = '0;
      m_valid = 1'b1;
    end else if (cke_i) begin
      if (TIMER_SAMPLE) m_val = m_cnt;
      if (TIMER_ENABLE) m_cnt = m_cnt + 64'd1;
    end
  end

  // Compare process: model check every cycle, plus requested literal checks.
  always @(negedge clk_i) begin
    if (m_valid) begin
      checks++;
      if (TIMER_VALUE !== m_val) begin
        errors++;
        $display("FAIL model t=%0t TIMER_VALUE=%h expected=%h", $time, TIMER_VALUE, m_val);
      end
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      checks++;
      if (TIMER_VALUE !== lit_exp) begin
        errors++;
        $display("FAIL %s TIMER_VALUE=%0d expected=%0d", lit_name, TIMER_VALUE, lit_exp);
      end
    end
  end

  task automatic tick(input logic a, input logic c, input logic e, input logic s);
    arst_i       = a;
    cke_i        = c;
    TIMER_ENABLE = e;
    TIMER_SAMPLE = s;
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic [W-1:0] v);
    lit_name = name;
    lit_exp  = v;
    lit_seq++;
  endtask

  initial begin
    // Basic count: E1 reset, E2 idle, enable from E3, samples at E4 and E1006
    tick(1, 1, 0, 0);                     // E1
    tick(0, 1, 0, 0);                     // E2
    tick(0, 1, 1, 0);                     // E3
    tick(0, 1, 1, 1);                     // E4
    expect_lit("first_sample", 64'd1);
    for (int i = 5; i <= 1005; i++) tick(0, 1, 1, 0);
    tick(0, 1, 1, 1);                     // E1006
    expect_lit("second_sample", 64'd1003);

    // Reset after 50 counts; the sample on the reset edge is ignored
    tick(1, 1, 0, 0);
    for (int i = 0; i < 50; i++) tick(0, 1, 1, 0);
    tick(0, 1, 1, 1);
    expect_lit("pre_reset_sample", 64'd50);
    tick(1, 1, 1, 1);
    expect_lit("reset_clears_value", 64'd0);
    tick(0, 1, 0, 1);
    expect_lit("reset_clears_cnt", 64'd0);
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0);
    tick(1, 0, 1, 1);
    tick(0, 1, 0, 1);
    expect_lit("reset_ignores_cke", 64'd0);

    // Pause and resume
    for (int i = 0; i < 10; i++) tick(0, 1, 1, 0);
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
    expect_lit("pause_sample", 64'd10);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 0);
    tick(0, 1, 0, 1);
    expect_lit("resume_sample", 64'd15);

    // cke_i gating: 7 stalled cycles in a 20-cycle enabled window
    tick(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);
    tick(0, 1, 0, 1);
    expect_lit("cke_pre_sample", 64'd4);
    for (int i = 0; i < 20; i++) begin
      if (i >= 8 && i < 15) begin
        tick(0, 0, 1, (i == 10) ? 1'b1 : 1'b0);
        if (i == 10) expect_lit("cke_blocks_sample", 64'd4);
      end else begin
        tick(0, 1, 1, 0);
      end
    end
    tick(0, 1, 0, 1);
    expect_lit("cke_window_count", 64'd17);

    // Continuous sample: value tracks cnt with one-cycle lag
    tick(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 1, 1);
      expect_lit("continuous_sample", 64'(5 + i));
    end

    // Wrap: deposit near full scale, then count through zero
    tick(0, 1, 0, 0);
    dep_val = 64'hFFFF_FFFF_FFFF_FFFE;
    dep_seq++;
    force dut.cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    tick(0, 1, 0, 0);
    release dut.cnt;
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 1);
    expect_lit("wrap_full_scale", 64'hFFFF_FFFF_FFFF_FFFF);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 1);
    expect_lit("wrap_to_one", 64'd1);

    // Random traffic against the model
    tick(1, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    tick(0, 1, 0, 0);
    @(negedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
